mips_cache_instr_assoc: RTL and testbench
=========================================

# mips_cache_instr_assoc

Parametrised N-way set-associative, read-only instruction cache with multi-word lines, tree pseudo-LRU replacement and a whole-cache flush. It sits between the CPU fetch stage and the cache controller. It replaces the fixed 4-way, one-word-line instruction cache. Misses are serviced by a refill state machine that fetches a full line, one word per controller handshake.

## Interface
- WAY_BITS, default 2: log2 of the number of ways (WAYS = 2^WAY_BITS, 1..8).
- SET_BITS, default 3: log2 of the number of sets.
- WORD_BITS, default 2: log2 of the number of 32-bit words per line (WORDS = 2^WORD_BITS).
- Address split: byte [1:0], word [WORD_BITS+1:2], index [SET_BITS+WORD_BITS+1:WORD_BITS+2], tag = the remaining upper bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  one clock; reset is synchronous and active-low. Cache is reset while rst==0 at a rising edge.
- addr  in  32  fetch byte address; word-aligned.
- read_en  in  1  fetch request.
- readdata  out  32  instruction word; valid while read_en=1 and stall=0.
- stall  out  1  CPU must hold addr/read_en and freeze.
- flush  in  1  single-cycle pulse; invalidates all lines.
- mem_req  out  1  word request to the controller.
- mem_addr  out  32  requested word address.
- mem_data  in  32  returned word.
- mem_valid  in  1  mem_data valid for the current mem_addr.

## Operation
- Per set: WAYS × {valid, tag, WORDS data words}, plus WAYS-1 PLRU tree bits.
- Lookup is combinational on addr. hit = some valid way has a matching tag. readdata = word[addr word field] of the hit way.
- States: IDLE, REFILL, FLUSH.
- **IDLE:**
  - read_en & hit: stall=0. PLRU bits on the path to the hit way are set to point away from it (node bit = 1 if the accessed way is in the lower half, else 0).
  - read_en & miss: stall=1. Latch line base (addr with word and byte fields zeroed), index and tag.
  - Victim way: lowest-numbered invalid way; if all ways are valid, follow the PLRU bits from the root (bit 0 → lower half).
  - Clear the victim's valid bit, set k=0, go to REFILL.
  - flush (takes priority over a miss in the same cycle): go to FLUSH.
- **REFILL:**
  - mem_req=1, mem_addr = line_base + 4k, held stable until mem_valid.
  - On mem_valid: write mem_data into victim word k, k++.
  - On the last word: write tag, set valid, update PLRU with the victim as MRU, go to IDLE.
  - stall=1 throughout. mem_req drops in the cycle after the last mem_valid.
- **FLUSH:**
  - Counter s = 0..SETS-1; one set per cycle, clearing its valid and PLRU bits.
  - stall=1 while read_en. Return to IDLE after s=SETS-1.
- A flush pulse during REFILL is recorded as pending. FLUSH is entered on completion of the refill instead of IDLE.
- read_en=0: stall=0, no PLRU update, no refill started. readdata is don't-care.
- If addr changes after a refill completes, the new addr is looked up normally.
- Reset (rst==0 at an edge, in any state, including mid-refill): all valid and PLRU bits = 0, state=IDLE, k=0, pending flush=0, mem_req=0, mem_addr=0.
  - stall reflects only read_en and the lookup (IDLE with all lines invalid: stall = read_en).
  - A mem_valid arriving after reset is ignored.

## Timing
- Hit: zero-cycle latency. readdata and stall=0 are valid in the same cycle as addr.
- Miss, with mem_valid returned in the first cycle of each request: detection in cycle 0, mem_req high in cycles 1..WORDS, hit in cycle WORDS+1. Miss penalty is WORDS+1 stall cycles, plus any mem_valid wait cycles.
- Flush costs SETS cycles, plus the remainder of any refill in progress.
- The controller may hold mem_valid low for any number of cycles. The cache never aborts a refill except by reset.

## Test plan
- Cold miss, default params, addr=0x0000_0040:
  - mem_addr sequence 0x40, 0x44, 0x48, 0x4C with mem_data 0xA0..0xA3.
  - stall high for 5 cycles.
  - Then addr 0x44, 0x4C give readdata 0xA1, 0xA3 with stall=0.
- PLRU replacement in set 0:
  - Fill tags at 0x000, 0x080, 0x100, 0x180, hit 0x000, then miss 0x200: the victim is way 2 (0x100).
  - A re-fetch of 0x100 misses; a re-fetch of 0x000 hits.
- mem_valid delayed 3 cycles on each word: mem_addr is held stable and mem_req stays high; readdata is correct afterwards; the penalty is 17 cycles.
- flush pulse after filling 4 lines: FLUSH lasts 8 cycles; every prior address misses afterwards.
- flush asserted mid-refill: the refill completes, then FLUSH runs; the just-filled line misses.
- rst=0 during word 2 of a refill: next cycle mem_req=0; the line at that address misses and the refill restarts from word 0.
- Parameter sweep: WAY_BITS=0 and 3, WORD_BITS=0 and 3. Refill word counts and victim choice match the rules above.

Source files
------------

// File: rtl/mips_cache_instr_assoc_if.sv
// ---------------------------------------------------------------------------
// mips_cache_instr_assoc_if
//
// Purpose: bundles the fetch-side and refill-side signals of the
// set-associative instruction cache into one interface.
//
// Signals:
//   addr      fetch byte address (word aligned)
//   read_en   fetch request
//   readdata  instruction word returned on a hit
//   stall     CPU must hold addr/read_en and freeze
//   flush     single-cycle pulse, invalidates the whole cache
//   mem_req   word request towards the cache controller
//   mem_addr  word address being requested
//   mem_data  word returned by the controller
//   mem_valid mem_data is valid for the current mem_addr
//
// Modports:
//   master  CPU + controller side (drives requests and refill data)
//   slave   cache side
// ---------------------------------------------------------------------------
interface mips_cache_instr_assoc_if;
   logic [31:0] addr;
   logic        read_en;
   logic [31:0] readdata;
   logic        stall;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_valid;

   modport master (
      output addr, read_en, flush, mem_data, mem_valid,
      input  readdata, stall, mem_req, mem_addr
   );

   modport slave (
      input  addr, read_en, flush, mem_data, mem_valid,
      output readdata, stall, mem_req, mem_addr
   );
endinterface

// File: rtl/mips_cache_instr_assoc.sv
// ---------------------------------------------------------------------------
// mips_cache_instr_assoc
//
// Purpose: N-way set-associative, read-only instruction cache with
// multi-word lines, tree pseudo-LRU replacement and a whole-cache flush.
// Hits are answered combinationally; misses fetch the full line from the
// cache controller one word per mem_valid handshake.
//
// Parameters:
//   WAY_BITS   log2 of the number of ways
//   SET_BITS   log2 of the number of sets
//   WORD_BITS  log2 of the number of 32-bit words per line
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   synchronous active-low reset
//   bus   slave side of mips_cache_instr_assoc_if (fetch + refill signals)
// ---------------------------------------------------------------------------
module mips_cache_instr_assoc #(
   parameter int WAY_BITS  = 2,
   parameter int SET_BITS  = 3,
   parameter int WORD_BITS = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   mips_cache_instr_assoc_if.slave  bus
);

   localparam int WAYS    = 1 << WAY_BITS;
   localparam int SETS    = 1 << SET_BITS;
   localparam int WORDS   = 1 << WORD_BITS;
   localparam int IDX_LSB = WORD_BITS + 2;
   localparam int TAG_LSB = SET_BITS + WORD_BITS + 2;
   localparam int TAG_W   = 32 - TAG_LSB;
   localparam int WAY_W   = (WAY_BITS > 0) ? WAY_BITS : 1;
   localparam int SET_W   = (SET_BITS > 0) ? SET_BITS : 1;
   localparam int WORD_W  = (WORD_BITS > 0) ? WORD_BITS : 1;
   localparam int PLRU_W  = (WAYS > 1) ? WAYS - 1 : 1;

   typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

   // Cache storage; PLRU tree is heap ordered: node n has children 2n+1 / 2n+2
   logic [WAYS-1:0]   valid_q [SETS];
   logic [PLRU_W-1:0] plru_q  [SETS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [31:0]       data_q  [SETS][WAYS][WORDS];

   state_t            state_q;
   logic [WORD_W-1:0] k_q;
   logic [SET_W-1:0]  s_q;
   logic [SET_W-1:0]  r_idx;
   logic [TAG_W-1:0]  r_tag;
   logic [WAY_W-1:0]  r_way;
   logic              flush_pend;
   logic              mem_req_q;
   logic [31:0]       mem_addr_q;

   logic [SET_W-1:0]  cur_idx;
   logic [WORD_W-1:0] cur_word;
   logic [TAG_W-1:0]  cur_tag;
   logic [31:0]       line_base;
   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic              inv_any;
   logic [WAY_W-1:0]  inv_way;
   logic [WAY_W-1:0]  victim;
   logic              stall;

   // Mark a way as most recently used: every node on its path points away
   function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                    input logic [WAY_W-1:0]  way);
      logic [PLRU_W-1:0] nb;
      logic [WAY_W-1:0]  node;
      nb   = bits;
      node = '0;
      for (int l = WAY_BITS - 1; l >= 0; l--) begin
         nb[node] = ~way[l];
         node     = WAY_W'((32'(node) << 1) + 32'd1 + 32'(way[l]));
      end
      return nb;
   endfunction

   // Walk the tree from the root; a 0 bit leads into the lower half
   function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
      logic [WAY_W-1:0] way;
      logic [WAY_W-1:0] node;
      way  = '0;
      node = '0;
      for (int l = WAY_BITS - 1; l >= 0; l--) begin
         way[l] = bits[node];
         node   = WAY_W'((32'(node) << 1) + 32'd1 + 32'(bits[node]));
      end
      return way;
   endfunction

   assign cur_idx   = SET_W'((bus.addr >> IDX_LSB) & 32'(SETS - 1));
   assign cur_word  = WORD_W'((bus.addr >> 2) & 32'(WORDS - 1));
   assign cur_tag   = bus.addr[31:TAG_LSB];
   assign line_base = bus.addr & ~32'(WORDS * 4 - 1);

   // Tag match and lowest invalid way; the descending scan lets the lowest way win
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[cur_idx][w] && (tag_q[cur_idx][w] == cur_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[cur_idx][w]) begin
            inv_any = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
      victim = inv_any ? inv_way : plru_victim(plru_q[cur_idx]);
   end

   // Stall depends only on state, read_en and the lookup so hits cost nothing
   always_comb begin
      case (state_q)
         IDLE:    stall = bus.read_en && !hit;
         REFILL:  stall = 1'b1;
         default: stall = bus.read_en;
      endcase
   end

   assign bus.stall    = stall;
   assign bus.readdata = data_q[cur_idx][hit_way][cur_word];
   assign bus.mem_req  = mem_req_q;
   assign bus.mem_addr = mem_addr_q;

   // Control FSM: lookup/PLRU in IDLE, line refill, one-set-per-cycle flush.
   // A flush seen during a refill is parked and taken when the line completes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         k_q        <= '0;
         s_q        <= '0;
         flush_pend <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.flush) begin
                  state_q <= FLUSH;
                  s_q     <= '0;
               end else if (bus.read_en && hit) begin
                  plru_q[cur_idx] <= plru_touch(plru_q[cur_idx], hit_way);
               end else if (bus.read_en) begin
                  r_idx                    <= cur_idx;
                  r_tag                    <= cur_tag;
                  r_way                    <= victim;
                  valid_q[cur_idx][victim] <= 1'b0;
                  k_q                      <= '0;
                  mem_req_q                <= 1'b1;
                  mem_addr_q               <= line_base;
                  state_q                  <= REFILL;
               end
            end
            REFILL: begin
               if (bus.flush) begin
                  flush_pend <= 1'b1;
               end
               if (bus.mem_valid) begin
                  k_q        <= k_q + WORD_W'(1);
                  mem_addr_q <= mem_addr_q + 32'd4;
                  if (k_q == WORD_W'(WORDS - 1)) begin
                     valid_q[r_idx][r_way] <= 1'b1;
                     plru_q[r_idx]         <= plru_touch(plru_q[r_idx], r_way);
                     mem_req_q             <= 1'b0;
                     if (flush_pend || bus.flush) begin
                        state_q    <= FLUSH;
                        s_q        <= '0;
                        flush_pend <= 1'b0;
                     end else begin
                        state_q <= IDLE;
                     end
                  end
               end
            end
            FLUSH: begin
               valid_q[s_q] <= '0;
               plru_q[s_q]  <= '0;
               s_q          <= s_q + SET_W'(1);
               if (s_q == SET_W'(SETS - 1)) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Line data and tag arrays need no reset: valid bits gate every use
   always_ff @(posedge clk) begin
      if (rst && (state_q == REFILL) && bus.mem_valid) begin
         data_q[r_idx][r_way][k_q] <= bus.mem_data;
         if (k_q == WORD_W'(WORDS - 1)) begin
            tag_q[r_idx][r_way] <= r_tag;
         end
      end
   end

endmodule

// File: tb/tb_mips_cache_instr_assoc.sv
// ---------------------------------------------------------------------------
// tb_mips_cache_instr_assoc
//
// Purpose: self-checking bench for mips_cache_instr_assoc. Three instances
// (default geometry, 1-way/8-word lines, 8-way/1-word lines) share the same
// stimulus; only the selected one is out of reset, the others are held in
// reset. Main memory returns 0x90 + (address >> 2) for every word.
// ---------------------------------------------------------------------------
module tb_mips_cache_instr_assoc;

   logic        clk = 1'b0;
   logic [2:0]  rst_n = 3'b000;
   logic [31:0] addr = '0;
   logic        read_en = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] mem_data = '0;
   logic        mem_valid = 1'b0;
   int          sel = 0;

   int n_vec = 0;
   int n_fail = 0;
   int stall_cnt = 0;

   logic        cur_stall;
   logic [31:0] cur_rd;
   logic        cur_mem_req;
   logic [31:0] cur_mem_addr;

   mips_cache_instr_assoc_if bus0 ();
   mips_cache_instr_assoc_if bus1 ();
   mips_cache_instr_assoc_if bus2 ();

   assign bus0.addr = addr;  assign bus0.read_en = read_en;  assign bus0.flush = flush;
   assign bus0.mem_data = mem_data;  assign bus0.mem_valid = mem_valid;
   assign bus1.addr = addr;  assign bus1.read_en = read_en;  assign bus1.flush = flush;
   assign bus1.mem_data = mem_data;  assign bus1.mem_valid = mem_valid;
   assign bus2.addr = addr;  assign bus2.read_en = read_en;  assign bus2.flush = flush;
   assign bus2.mem_data = mem_data;  assign bus2.mem_valid = mem_valid;

   mips_cache_instr_assoc #(.WAY_BITS(2), .SET_BITS(3), .WORD_BITS(2)) dut0 (
      .clk(clk), .rst(rst_n[0]), .bus(bus0));
   mips_cache_instr_assoc #(.WAY_BITS(0), .SET_BITS(3), .WORD_BITS(3)) dut1 (
      .clk(clk), .rst(rst_n[1]), .bus(bus1));
   mips_cache_instr_assoc #(.WAY_BITS(3), .SET_BITS(3), .WORD_BITS(0)) dut2 (
      .clk(clk), .rst(rst_n[2]), .bus(bus2));

   // Observe whichever instance is currently under test
   always_comb begin
      cur_stall    = (sel == 0) ? bus0.stall    : (sel == 1) ? bus1.stall    : bus2.stall;
      cur_rd       = (sel == 0) ? bus0.readdata : (sel == 1) ? bus1.readdata : bus2.readdata;
      cur_mem_req  = (sel == 0) ? bus0.mem_req  : (sel == 1) ? bus1.mem_req  : bus2.mem_req;
      cur_mem_addr = (sel == 0) ? bus0.mem_addr : (sel == 1) ? bus1.mem_addr : bus2.mem_addr;
   end

   always #5 clk = ~clk;

   // Hard stop in case a sequence never returns
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return 32'h90 + (a >> 2);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Drive a fetch at the falling edge, then settle before sampling
   task automatic applyStimulus(input logic [31:0] a, input logic re);
      @(negedge clk);
      addr    = a;
      read_en = re;
      #2;
   endtask

   // Answer one line refill word by word, dly idle cycles before each word
   task automatic serveWords(input logic [31:0] base, input int words, input int dly,
                             input int flush_word);
      for (int w = 0; w < words; w++) begin
         for (int d = 0; d <= dly; d++) begin
            @(negedge clk);
            mem_valid = (d == dly);
            mem_data  = memWord(base + 32'(4 * w));
            flush     = (d == dly) && (w == flush_word);
            #2;
            if (cur_stall) stall_cnt++;
            checkOutput("refill_mem_req", 32'(cur_mem_req), 32'd1);
            checkOutput("refill_mem_addr", cur_mem_addr, base + 32'(4 * w));
         end
      end
   endtask

   task automatic endRefill();
      @(negedge clk);
      mem_valid = 1'b0;
      flush     = 1'b0;
      #2;
   endtask

   task automatic checkHit(input logic [31:0] a);
      applyStimulus(a, 1'b1);
      checkOutput("hit_stall", 32'(cur_stall), 32'd0);
      checkOutput("hit_data", cur_rd, memWord(a));
   endtask

   task automatic missAndRefill(input logic [31:0] a, input int words, input int dly);
      logic [31:0] base;
      int guard;
      base = a & ~(32'(words * 4) - 32'd1);
      applyStimulus(a, 1'b1);
      checkOutput("miss_detect", 32'(cur_stall), 32'd1);
      stall_cnt = cur_stall ? 1 : 0;
      serveWords(base, words, dly, -1);
      endRefill();
      guard = 0;
      while (cur_stall && guard < 60) begin
         stall_cnt++;
         guard++;
         @(negedge clk);
         #2;
      end
      checkOutput("miss_penalty", 32'(stall_cnt), 32'(words * (dly + 1) + 1));
      checkOutput("mem_req_drop", 32'(cur_mem_req), 32'd0);
      checkOutput("refill_data", cur_rd, memWord(a));
   endtask

   // Count cycles until mem_req rises (bounded)
   task automatic cyclesToMemReq(output int cyc);
      cyc = 1;
      while (!cur_mem_req && cyc < 60) begin
         @(negedge clk);
         #2;
         cyc++;
      end
   endtask

   task automatic selectInstance(input int which);
      @(negedge clk);
      read_en   = 1'b0;
      mem_valid = 1'b0;
      flush     = 1'b0;
      rst_n     = 3'b000;
      sel       = which;
      @(negedge clk);
      rst_n[which] = 1'b1;
      @(negedge clk);
   endtask

   typedef struct {
      logic [31:0] a;
      logic        re;
      logic        exp_stall;
      logic        chk_data;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[7];
   int   cyc;

   initial begin
      // Lookups after the cold miss of line 0x40 (data 0xA0..0xA3)
      vecs[0] = '{32'h0000_0040, 1'b1, 1'b0, 1'b1, 32'h0000_00A0};
      vecs[1] = '{32'h0000_0044, 1'b1, 1'b0, 1'b1, 32'h0000_00A1};
      vecs[2] = '{32'h0000_0048, 1'b1, 1'b0, 1'b1, 32'h0000_00A2};
      vecs[3] = '{32'h0000_004C, 1'b1, 1'b0, 1'b1, 32'h0000_00A3};
      vecs[4] = '{32'h0000_0080, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
      vecs[5] = '{32'h0001_2340, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
      vecs[6] = '{32'h0000_0044, 1'b1, 1'b0, 1'b1, 32'h0000_00A1};

      // Reset behaviour of the default instance
      repeat (2) @(negedge clk);
      applyStimulus(32'h40, 1'b1);
      checkOutput("rst_stall_read", 32'(cur_stall), 32'd1);
      checkOutput("rst_mem_req", 32'(cur_mem_req), 32'd0);
      checkOutput("rst_mem_addr", cur_mem_addr, 32'd0);
      @(negedge clk);
      read_en  = 1'b0;
      rst_n[0] = 1'b1;
      applyStimulus(32'h40, 1'b0);
      checkOutput("idle_stall_noread", 32'(cur_stall), 32'd0);
      checkOutput("idle_mem_req", 32'(cur_mem_req), 32'd0);

      // Cold miss: 4-word refill, 5 stall cycles
      missAndRefill(32'h40, 4, 0);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].a, vecs[i].re);
         checkOutput($sformatf("vec%0d_stall", i), 32'(cur_stall), 32'(vecs[i].exp_stall));
         if (vecs[i].chk_data)
            checkOutput($sformatf("vec%0d_data", i), cur_rd, vecs[i].exp_data);
      end

      // PLRU: fill set 0, touch way 0, new tag must evict way 2 (0x100)
      missAndRefill(32'h000, 4, 0);
      missAndRefill(32'h080, 4, 0);
      missAndRefill(32'h100, 4, 0);
      missAndRefill(32'h180, 4, 0);
      checkHit(32'h000);
      missAndRefill(32'h200, 4, 0);
      checkHit(32'h004);
      checkHit(32'h088);
      checkHit(32'h18C);
      missAndRefill(32'h100, 4, 0);

      // Slow controller: 3 wait cycles per word, penalty 17
      missAndRefill(32'h414, 4, 3);
      checkHit(32'h41C);

      // Flush pulse: 8 FLUSH cycles, then an old address misses again
      @(negedge clk);
      read_en = 1'b0;
      flush   = 1'b1;
      #2;
      @(negedge clk);
      flush   = 1'b0;
      addr    = 32'h40;
      read_en = 1'b1;
      #2;
      cyclesToMemReq(cyc);
      checkOutput("flush_length", 32'(cyc), 32'd10);
      checkOutput("flush_refetch_addr", cur_mem_addr, 32'h40);
      serveWords(32'h40, 4, 0, -1);
      endRefill();
      checkOutput("flush_refill_stall", 32'(cur_stall), 32'd0);
      checkOutput("flush_refill_data", cur_rd, 32'hA0);
      missAndRefill(32'h000, 4, 0);
      missAndRefill(32'h410, 4, 0);

      // Flush during a refill: the line completes, FLUSH runs, line misses
      applyStimulus(32'h500, 1'b1);
      checkOutput("mr_miss", 32'(cur_stall), 32'd1);
      serveWords(32'h500, 4, 0, 1);
      endRefill();
      checkOutput("mr_flush_stall", 32'(cur_stall), 32'd1);
      checkOutput("mr_flush_mem_req", 32'(cur_mem_req), 32'd0);
      cyclesToMemReq(cyc);
      checkOutput("mr_flush_length", 32'(cyc), 32'd10);
      checkOutput("mr_refetch_addr", cur_mem_addr, 32'h500);
      serveWords(32'h500, 4, 0, -1);
      endRefill();
      checkOutput("mr_refill_data", cur_rd, memWord(32'h500));

      // Reset during word 2 of a refill: refill restarts from word 0
      applyStimulus(32'h610, 1'b1);
      checkOutput("rr_miss", 32'(cur_stall), 32'd1);
      serveWords(32'h610, 2, 0, -1);
      @(negedge clk);
      mem_valid = 1'b1;
      mem_data  = memWord(32'h618);
      rst_n[0]  = 1'b0;
      #2;
      @(negedge clk);
      rst_n[0]  = 1'b1;
      mem_valid = 1'b1;
      mem_data  = 32'hDEAD_BEEF;
      #2;
      checkOutput("rr_mem_req", 32'(cur_mem_req), 32'd0);
      checkOutput("rr_mem_addr", cur_mem_addr, 32'd0);
      checkOutput("rr_stall", 32'(cur_stall), 32'd1);
      serveWords(32'h610, 4, 0, -1);
      endRefill();
      checkOutput("rr_stall_done", 32'(cur_stall), 32'd0);
      checkOutput("rr_data", cur_rd, memWord(32'h610));
      missAndRefill(32'h44, 4, 0);

      // One way, eight-word lines
      selectInstance(1);
      missAndRefill(32'h24, 8, 0);
      checkHit(32'h3C);
      missAndRefill(32'h124, 8, 1);
      missAndRefill(32'h20, 8, 0);

      // Eight ways, one-word lines: fill set 0, touch way 0, evict way 4
      selectInstance(2);
      for (int i = 0; i < 8; i++) begin
         missAndRefill(32'(32 * i), 1, 0);
      end
      checkHit(32'h00);
      missAndRefill(32'h100, 1, 0);
      checkHit(32'h00);
      checkHit(32'h20);
      checkHit(32'hE0);
      checkHit(32'h100);
      missAndRefill(32'h80, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
